// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter and its helpers.
// Holds the arbiter state encoding, the default sizing parameters and
// the fixed master index assignment used across the bus fabric.
package bus_arbiter_pkg;

  // Default sizing for the arbiter instance on the data-memory bus
  localparam int DEF_NUM_MST  = 4;
  localparam int DEF_MAX_LOCK = 16;

  // Fixed master positions on the request/grant vectors
  localparam int MST_CPU = 0;
  localparam int MST_DMA = 1;
  localparam int MST_DBG = 2;

  // Two-bit encoding so an illegal value exists and can be recovered from
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCKED = 2'd1
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
// Searches req starting at ptr+1 and wrapping modulo N; the first set bit
// wins. Generic enough to be shared with the interrupt controller.
// Ports:
//   req   - request vector, bit i belongs to requester i
//   ptr   - index of the previous winner (search starts just after it)
//   grant - one-hot winner, zero when no request
//   idx   - index of the winner, zero when no request
//   valid - at least one request present
module bus_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Walk the N candidates in rotated order; the previous winner is the
  // last one visited so it has the lowest priority this round.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDX_W'((int'(ptr) + off) % N);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared data-memory bus.
// Grants are combinational in the request cycle so a free bus completes a
// single-cycle access immediately. A master may lock the bus for a burst;
// a watchdog breaks any lock after MAX_LOCK granted cycles and blocks that
// master from relocking until it drops its lock request.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   mst_req      - per-master bus request
//   mst_lock     - per-master lock request, meaningful only with mst_req
//   mst_grant    - one-hot-or-zero grant, combinational
//   bus_busy     - OR of mst_grant
//   owner        - index of the granted master, holds when no grant
//   locked       - registered, high while the bus is locked
//   lock_timeout - registered one-cycle pulse when a lock is broken
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MST  = DEF_NUM_MST,
  parameter int MAX_LOCK = DEF_MAX_LOCK,
  parameter int IDX_W    = $clog2(NUM_MST)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_MST-1:0] mst_req,
  input  logic [NUM_MST-1:0] mst_lock,
  output logic [NUM_MST-1:0] mst_grant,
  output logic               bus_busy,
  output logic [IDX_W-1:0]   owner,
  output logic               locked,
  output logic               lock_timeout
);

  localparam int                 CNT_W    = $clog2(MAX_LOCK) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_LOCK - 1);
  localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(NUM_MST - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_MST-1:0] blk_q, blk_d;
  logic               timeout_d;
  logic [NUM_MST-1:0] grant_raw;

  logic [NUM_MST-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  bus_arbiter_rr_pick #(
    .N     (NUM_MST),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (mst_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next-state and grant logic. In IDLE the rotating picker decides and the
  // owner output follows the winner in the same cycle; in LOCKED only the
  // registered owner can be granted. The lock counter already counts the
  // IDLE grant cycle, so breaking at MAX_LOCK-1 caps a burst at MAX_LOCK
  // granted cycles. blk drops as soon as a master releases its lock line.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q & mst_lock;
    timeout_d = 1'b0;
    grant_raw = '0;
    owner     = owner_q;
    case (state_q)
      ARB_IDLE: begin
        grant_raw = pick_grant;
        if (pick_valid) begin
          owner   = pick_idx;
          ptr_d   = pick_idx;
          owner_d = pick_idx;
          if (mst_lock[pick_idx] && !blk_q[pick_idx]) begin
            state_d = ARB_LOCKED;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        grant_raw[owner_q] = mst_req[owner_q];
        if (!mst_req[owner_q] || !mst_lock[owner_q]) begin
          state_d = ARB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = ARB_IDLE;
          timeout_d      = 1'b1;
          blk_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Grants are suppressed for the whole reset pulse, not just after it
  assign mst_grant = rst ? '0 : grant_raw;
  assign bus_busy  = |mst_grant;

  // State register; ptr resets to the last master so master 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= PTR_RST;
      owner_q      <= '0;
      cnt_q        <= '0;
      blk_q        <= '0;
      locked       <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      locked       <= (state_d == ARB_LOCKED);
      lock_timeout <= timeout_d;
    end
  end

endmodule
